// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchronizer, debounce and auto-repeat press strobe
module button_conditioner #(
    parameter int NUM_BTN     = 2,
    parameter int CLK_FREQ    = 6000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 200,
    parameter int REPEAT_EN   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level
);
    localparam int DB_CYC   = CLK_FREQ * DEBOUNCE_MS / 1000;
    localparam int HOLD_CYC = CLK_FREQ * HOLD_MS / 1000;
    localparam int REP_CYC  = CLK_FREQ * REPEAT_MS / 1000;
    localparam int MAX_DH   = (DB_CYC > HOLD_CYC) ? DB_CYC : HOLD_CYC;
    localparam int MAX_CYC  = (MAX_DH > REP_CYC) ? MAX_DH : REP_CYC;
    localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (DB_CYC < 1 || HOLD_CYC < 1 || REP_CYC < 1) begin : g_bad_cfg
        $error("button_conditioner: derived cycle counts must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        REPEAT,
        DB_RELEASE
    } state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic             sync_1;
        logic             sync_2;
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             pulse_q;
        logic             pulse_nxt;
        logic             level_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_1  <= 1'b0;
                sync_2  <= 1'b0;
                state   <= IDLE;
                cnt     <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                sync_1  <= btn_raw[i];
                sync_2  <= sync_1;
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                pulse_q <= pulse_nxt;
                // Level is high in every state that follows an accepted press.
                level_q <= (state_nxt == PRESSED) || (state_nxt == REPEAT) ||
                           (state_nxt == DB_RELEASE);
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pulse_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (sync_2) begin
                        state_nxt = DB_PRESS;
                        cnt_nxt   = '0;
                    end
                end
                DB_PRESS: begin
                    if (!sync_2) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DB_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_2) begin
                        state_nxt = DB_RELEASE;
                        cnt_nxt   = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (cnt == HOLD_LAST) begin
                            state_nxt = REPEAT;
                            cnt_nxt   = '0;
                            pulse_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (!sync_2) begin
                        state_nxt = DB_RELEASE;
                        cnt_nxt   = '0;
                    end else if (cnt == REP_LAST) begin
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                DB_RELEASE: begin
                    // A bounce back high re-arms the hold timer without a new pulse.
                    if (sync_2) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == DB_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign btn_pulse[i] = pulse_q;
        assign btn_level[i] = level_q;
    end

endmodule
